// File: rtl/discharge_pulse_scheduler.sv
// rtl/discharge_pulse_scheduler.sv - EDM discharge pulse sequencer (gap open, breakdown wait, Ton, Toff)
module discharge_pulse_scheduler #(
    parameter int TW = 32,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          stop,
    input  logic          breakdown,
    input  logic          short_circuit,
    input  logic [15:0]   waveform_in,
    input  logic [15:0]   Ip_in,
    input  logic [TW-1:0] Ton_in,
    input  logic [TW-1:0] Toff_in,
    input  logic [TW-1:0] Tw_max_in,
    output logic [TW-1:0] timer_buck_interleave,
    output logic [15:0]   waveform,
    output logic [15:0]   Ip,
    output logic [TW-1:0] Ton_timer,
    output logic          gap_voltage_on,
    output logic          discharge_on,
    output logic          buck_phase,
    output logic          pulse_done,
    output logic [CW-1:0] pulse_count,
    output logic [CW-1:0] open_count,
    output logic [CW-1:0] short_count,
    output logic          config_err
);

    typedef enum logic [1:0] {IDLE, WAIT_BD, DISCHARGE, REST} state_t;

    localparam logic [TW-1:0] T_ONE = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state;
    logic [TW-1:0] toff_q;
    logic [TW-1:0] tw_max_q;
    logic [TW-1:0] wait_cnt;
    logic [TW-1:0] rest_cnt;
    logic [TW-1:0] rest_end;

    // A zero rest time still costs one REST cycle.
    assign rest_end = (toff_q == '0) ? T_ONE : toff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            toff_q                <= '0;
            tw_max_q              <= '0;
            wait_cnt              <= '0;
            rest_cnt              <= '0;
            timer_buck_interleave <= '0;
            waveform              <= '0;
            Ip                    <= '0;
            Ton_timer             <= '0;
            gap_voltage_on        <= 1'b0;
            discharge_on          <= 1'b0;
            buck_phase            <= 1'b0;
            pulse_done            <= 1'b0;
            pulse_count           <= '0;
            open_count            <= '0;
            short_count           <= '0;
            config_err            <= 1'b0;
        end else begin
            pulse_done <= 1'b0;
            if (stop) begin
                state                 <= IDLE;
                timer_buck_interleave <= '0;
                gap_voltage_on        <= 1'b0;
                discharge_on          <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            if (Ton_in == '0) begin
                                config_err <= 1'b1;
                            end else begin
                                waveform       <= waveform_in;
                                Ip             <= Ip_in;
                                Ton_timer      <= Ton_in;
                                toff_q         <= Toff_in;
                                tw_max_q       <= Tw_max_in;
                                wait_cnt       <= T_ONE;
                                gap_voltage_on <= 1'b1;
                                state          <= WAIT_BD;
                            end
                        end
                    end
                    WAIT_BD: begin
                        if (short_circuit) begin
                            short_count    <= short_count + C_ONE;
                            rest_cnt       <= T_ONE;
                            gap_voltage_on <= 1'b0;
                            state          <= REST;
                        end else if (breakdown) begin
                            buck_phase            <= ~buck_phase;
                            timer_buck_interleave <= T_ONE;
                            discharge_on          <= 1'b1;
                            state                 <= DISCHARGE;
                        end else if (tw_max_q != '0 && wait_cnt == tw_max_q) begin
                            open_count     <= open_count + C_ONE;
                            rest_cnt       <= T_ONE;
                            gap_voltage_on <= 1'b0;
                            state          <= REST;
                        end else begin
                            wait_cnt <= wait_cnt + T_ONE;
                        end
                    end
                    DISCHARGE: begin
                        if (timer_buck_interleave == Ton_timer) begin
                            timer_buck_interleave <= '0;
                            pulse_done            <= 1'b1;
                            pulse_count           <= pulse_count + C_ONE;
                            discharge_on          <= 1'b0;
                            gap_voltage_on        <= 1'b0;
                            rest_cnt              <= T_ONE;
                            state                 <= REST;
                        end else begin
                            timer_buck_interleave <= timer_buck_interleave + T_ONE;
                        end
                    end
                    REST: begin
                        if (rest_cnt == rest_end) begin
                            state <= IDLE;
                        end else begin
                            rest_cnt <= rest_cnt + T_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_discharge_pulse_scheduler.sv
// tb/tb_discharge_pulse_scheduler.sv - self-checking bench for discharge_pulse_scheduler
module tb_discharge_pulse_scheduler;

    localparam int TW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          stop = 1'b0;
    logic          breakdown = 1'b0;
    logic          short_circuit = 1'b0;
    logic [15:0]   waveform_in = '0;
    logic [15:0]   Ip_in = '0;
    logic [TW-1:0] Ton_in = '0;
    logic [TW-1:0] Toff_in = '0;
    logic [TW-1:0] Tw_max_in = '0;
    logic [TW-1:0] timer_buck_interleave;
    logic [15:0]   waveform;
    logic [15:0]   Ip;
    logic [TW-1:0] Ton_timer;
    logic          gap_voltage_on;
    logic          discharge_on;
    logic          buck_phase;
    logic          pulse_done;
    logic [CW-1:0] pulse_count;
    logic [CW-1:0] open_count;
    logic [CW-1:0] short_count;
    logic          config_err;

    int checks = 0;
    int passes = 0;
    int exp_pulses = 0;
    int exp_opens = 0;
    int exp_shorts = 0;
    logic exp_buck = 1'b0;
    logic [TW-1:0] exp_timer_q[$];

    discharge_pulse_scheduler #(.TW(TW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stop(stop),
        .breakdown(breakdown), .short_circuit(short_circuit),
        .waveform_in(waveform_in), .Ip_in(Ip_in), .Ton_in(Ton_in),
        .Toff_in(Toff_in), .Tw_max_in(Tw_max_in),
        .timer_buck_interleave(timer_buck_interleave), .waveform(waveform),
        .Ip(Ip), .Ton_timer(Ton_timer), .gap_voltage_on(gap_voltage_on),
        .discharge_on(discharge_on), .buck_phase(buck_phase),
        .pulse_done(pulse_done), .pulse_count(pulse_count),
        .open_count(open_count), .short_count(short_count),
        .config_err(config_err)
    );

    always #5 clk = ~clk;

    task automatic set_cfg(input logic [15:0] w, input logic [15:0] ip,
                           input int ton, input int toff, input int twm);
        waveform_in = w;
        Ip_in       = ip;
        Ton_in      = TW'(ton);
        Toff_in     = TW'(toff);
        Tw_max_in   = TW'(twm);
    endtask

    task automatic test_reset();
        checks++;
        if ({timer_buck_interleave, waveform, Ip, Ton_timer, pulse_count, open_count, short_count} !== '0
            || {gap_voltage_on, discharge_on, buck_phase, pulse_done, config_err} !== 5'b0)
            $display("FAIL reset_values: timer=%0d gap=%b dis=%b pc=%0d err=%b required all zero",
                     timer_buck_interleave, gap_voltage_on, discharge_on, pulse_count, config_err);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (gap_voltage_on !== 1'b0) $display("FAIL idle_after_reset: gap=%b required 0", gap_voltage_on);
        else passes++;
    endtask

    task automatic test_basic_pulse();
        int n;
        int pd_extra;
        logic [TW-1:0] exp;
        set_cfg(16'hA5A5, 16'h0123, 5, 3, 10);
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (gap_voltage_on !== 1'b1 || discharge_on !== 1'b0)
            $display("FAIL t1_wait_bd_entry: gap=%b dis=%b required 1 0", gap_voltage_on, discharge_on);
        else passes++;
        enable = 1'b0;
        @(negedge clk);
        breakdown = 1'b1;
        exp_buck = ~exp_buck;
        for (int i = 1; i <= 5; i++) exp_timer_q.push_back(TW'(i));
        @(negedge clk);
        breakdown = 1'b0;
        while (exp_timer_q.size() > 0) begin
            exp = exp_timer_q.pop_front();
            checks++;
            if (timer_buck_interleave !== exp || discharge_on !== 1'b1 || pulse_done !== 1'b0)
                $display("FAIL t1_timer: timer=%0d dis=%b pd=%b required %0d 1 0",
                         timer_buck_interleave, discharge_on, pulse_done, exp);
            else passes++;
            @(negedge clk);
        end
        exp_pulses++;
        checks++;
        if (pulse_done !== 1'b1 || pulse_count !== CW'(exp_pulses) || timer_buck_interleave !== '0
            || discharge_on !== 1'b0 || waveform !== 16'hA5A5 || Ip !== 16'h0123 || Ton_timer !== TW'(5)
            || buck_phase !== exp_buck)
            $display("FAIL t1_pulse_end: pd=%b pc=%0d timer=%0d wf=%h ip=%h ton=%0d bp=%b required 1 %0d 0 a5a5 0123 5 %b",
                     pulse_done, pulse_count, timer_buck_interleave, waveform, Ip, Ton_timer, buck_phase,
                     exp_pulses, exp_buck);
        else passes++;
        enable = 1'b1;
        n = 0;
        pd_extra = 0;
        while (!gap_voltage_on && n < 50) begin
            @(negedge clk);
            n++;
            if (pulse_done) pd_extra++;
        end
        checks++;
        if (n !== 4 || pd_extra !== 0)
            $display("FAIL t1_rest_length: restart_after=%0d extra_done=%0d required 4 0", n, pd_extra);
        else passes++;
        enable = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (gap_voltage_on !== 1'b0 || pulse_count !== CW'(exp_pulses))
            $display("FAIL t1_stop_wait: gap=%b pc=%0d required 0 %0d", gap_voltage_on, pulse_count, exp_pulses);
        else passes++;
    endtask

    task automatic test_open_timeout();
        int n;
        int tbad;
        set_cfg(16'h0001, 16'h0002, 5, 2, 4);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        n = 0;
        tbad = 0;
        while (gap_voltage_on && n < 50) begin
            if (timer_buck_interleave !== '0 || discharge_on !== 1'b0) tbad++;
            @(negedge clk);
            n++;
        end
        exp_opens++;
        checks++;
        if (n !== 4 || tbad !== 0 || open_count !== CW'(exp_opens) || pulse_count !== CW'(exp_pulses))
            $display("FAIL t2_open: wait_cycles=%0d timer_bad=%0d oc=%0d pc=%0d required 4 0 %0d %0d",
                     n, tbad, open_count, pulse_count, exp_opens, exp_pulses);
        else passes++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_short();
        logic [TW-1:0] exp;
        set_cfg(16'h0003, 16'h0004, 6, 2, 0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        short_circuit = 1'b1;
        exp_shorts++;
        @(negedge clk);
        short_circuit = 1'b0;
        checks++;
        if (gap_voltage_on !== 1'b0 || discharge_on !== 1'b0 || short_count !== CW'(exp_shorts))
            $display("FAIL t3_short_wait: gap=%b dis=%b sc=%0d required 0 0 %0d",
                     gap_voltage_on, discharge_on, short_count, exp_shorts);
        else passes++;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        breakdown = 1'b1;
        exp_buck = ~exp_buck;
        for (int i = 1; i <= 6; i++) exp_timer_q.push_back(TW'(i));
        @(negedge clk);
        short_circuit = 1'b1;
        while (exp_timer_q.size() > 0) begin
            exp = exp_timer_q.pop_front();
            checks++;
            if (timer_buck_interleave !== exp || discharge_on !== 1'b1)
                $display("FAIL t3_short_in_discharge: timer=%0d dis=%b required %0d 1",
                         timer_buck_interleave, discharge_on, exp);
            else passes++;
            @(negedge clk);
        end
        short_circuit = 1'b0;
        breakdown = 1'b0;
        exp_pulses++;
        checks++;
        if (pulse_done !== 1'b1 || pulse_count !== CW'(exp_pulses) || short_count !== CW'(exp_shorts)
            || buck_phase !== exp_buck)
            $display("FAIL t3_counts: pd=%b pc=%0d sc=%0d bp=%b required 1 %0d %0d %b",
                     pulse_done, pulse_count, short_count, buck_phase, exp_pulses, exp_shorts, exp_buck);
        else passes++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stop();
        set_cfg(16'h0005, 16'h0006, 8, 2, 0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        breakdown = 1'b1;
        exp_buck = ~exp_buck;
        @(negedge clk);
        breakdown = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (timer_buck_interleave !== TW'(3))
            $display("FAIL t4_pre_stop: timer=%0d required 3", timer_buck_interleave);
        else passes++;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (timer_buck_interleave !== '0 || discharge_on !== 1'b0 || gap_voltage_on !== 1'b0
            || pulse_done !== 1'b0 || pulse_count !== CW'(exp_pulses) || Ton_timer !== TW'(8)
            || buck_phase !== exp_buck)
            $display("FAIL t4_stop: timer=%0d dis=%b gap=%b pd=%b pc=%0d ton=%0d bp=%b required 0 0 0 0 %0d 8 %b",
                     timer_buck_interleave, discharge_on, gap_voltage_on, pulse_done, pulse_count,
                     Ton_timer, buck_phase, exp_pulses, exp_buck);
        else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (gap_voltage_on !== 1'b0 || pulse_count !== CW'(exp_pulses))
            $display("FAIL t4_stays_idle: gap=%b pc=%0d required 0 %0d", gap_voltage_on, pulse_count, exp_pulses);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [TW-1:0] exp;
        set_cfg(16'h0007, 16'h0008, 8, 1, 0);
        enable = 1'b1;
        @(negedge clk);
        breakdown = 1'b1;
        exp_buck = ~exp_buck;
        for (int i = 1; i <= 8; i++) exp_timer_q.push_back(TW'(i));
        @(negedge clk);
        breakdown = 1'b0;
        Ton_in = TW'(2);
        while (exp_timer_q.size() > 0) begin
            exp = exp_timer_q.pop_front();
            checks++;
            if (timer_buck_interleave !== exp || Ton_timer !== TW'(8) || buck_phase !== exp_buck)
                $display("FAIL t5_first_pulse: timer=%0d ton=%0d bp=%b required %0d 8 %b",
                         timer_buck_interleave, Ton_timer, buck_phase, exp, exp_buck);
            else passes++;
            @(negedge clk);
        end
        exp_pulses++;
        n = 0;
        while (!gap_voltage_on && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 2 || Ton_timer !== TW'(2))
            $display("FAIL t5_restart: cycles=%0d ton=%0d required 2 2", n, Ton_timer);
        else passes++;
        breakdown = 1'b1;
        exp_buck = ~exp_buck;
        exp_timer_q.push_back(TW'(1));
        exp_timer_q.push_back(TW'(2));
        @(negedge clk);
        breakdown = 1'b0;
        enable = 1'b0;
        while (exp_timer_q.size() > 0) begin
            exp = exp_timer_q.pop_front();
            checks++;
            if (timer_buck_interleave !== exp || discharge_on !== 1'b1 || buck_phase !== exp_buck)
                $display("FAIL t5_second_pulse: timer=%0d dis=%b bp=%b required %0d 1 %b",
                         timer_buck_interleave, discharge_on, buck_phase, exp, exp_buck);
            else passes++;
            @(negedge clk);
        end
        exp_pulses++;
        checks++;
        if (pulse_done !== 1'b1 || discharge_on !== 1'b0 || pulse_count !== CW'(exp_pulses))
            $display("FAIL t5_second_end: pd=%b dis=%b pc=%0d required 1 0 %0d",
                     pulse_done, discharge_on, pulse_count, exp_pulses);
        else passes++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_config_err();
        logic [TW-1:0] exp;
        set_cfg(16'h0009, 16'h000A, 0, 1, 0);
        checks++;
        if (config_err !== 1'b0) $display("FAIL t6_err_clear: err=%b required 0", config_err);
        else passes++;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        checks++;
        if (config_err !== 1'b1 || gap_voltage_on !== 1'b0)
            $display("FAIL t6_config_err: err=%b gap=%b required 1 0", config_err, gap_voltage_on);
        else passes++;
        set_cfg(16'h000B, 16'h000C, 3, 1, 2);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        breakdown = 1'b1;
        exp_buck = ~exp_buck;
        for (int i = 1; i <= 3; i++) exp_timer_q.push_back(TW'(i));
        @(negedge clk);
        breakdown = 1'b0;
        checks++;
        if (discharge_on !== 1'b1 || open_count !== CW'(exp_opens))
            $display("FAIL t6_bd_vs_timeout: dis=%b oc=%0d required 1 %0d", discharge_on, open_count, exp_opens);
        else passes++;
        while (exp_timer_q.size() > 0) begin
            exp = exp_timer_q.pop_front();
            checks++;
            if (timer_buck_interleave !== exp)
                $display("FAIL t6_timer: timer=%0d required %0d", timer_buck_interleave, exp);
            else passes++;
            @(negedge clk);
        end
        exp_pulses++;
        checks++;
        if (pulse_count !== CW'(exp_pulses) || config_err !== 1'b1)
            $display("FAIL t6_end: pc=%0d err=%b required %0d 1", pulse_count, config_err, exp_pulses);
        else passes++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        set_cfg(16'h000D, 16'h000E, 6, 2, 0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        breakdown = 1'b1;
        @(negedge clk);
        breakdown = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({timer_buck_interleave, waveform, Ip, Ton_timer, pulse_count, open_count, short_count} !== '0
            || {gap_voltage_on, discharge_on, buck_phase, pulse_done, config_err} !== 5'b0)
            $display("FAIL async_reset: timer=%0d dis=%b pc=%0d err=%b bp=%b required all zero",
                     timer_buck_interleave, discharge_on, pulse_count, config_err, buck_phase);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_basic_pulse();
        test_open_timeout();
        test_short();
        test_stop();
        test_back_to_back();
        test_config_err();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
